// File: rtl/bf_io_arbiter.sv
// Round-robin merge of NUM_MACHINES output streams onto one tagged host stream, plus id-routed
// host input. Optional per-machine forwarded-word counters when BF_IO_ARB_STATS_EN is defined.
module bf_io_arbiter #(
    parameter int unsigned NUM_MACHINES = 4,
    parameter int unsigned WORD_SIZE    = 8,
    parameter int unsigned ID_W         = (NUM_MACHINES > 2) ? $clog2(NUM_MACHINES) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MACHINES*WORD_SIZE-1:0]  m_out_data,
    input  logic [NUM_MACHINES-1:0]            m_out_valid,
    output logic [NUM_MACHINES-1:0]            m_out_ready,
    output logic [WORD_SIZE-1:0]               host_out_data,
    output logic [ID_W-1:0]                    host_out_id,
    output logic                               host_out_valid,
    input  logic                               host_out_ready,
    input  logic [WORD_SIZE-1:0]               host_in_data,
    input  logic [ID_W-1:0]                    host_in_id,
    input  logic                               host_in_valid,
    output logic                               host_in_ready,
    output logic [WORD_SIZE-1:0]               m_in_data,
    output logic [NUM_MACHINES-1:0]            m_in_valid,
    input  logic [NUM_MACHINES-1:0]            m_in_ready,
    output logic                               err_bad_id,
    output logic [NUM_MACHINES*16-1:0]         stat_out_count
);

    localparam logic [0:0]      StEmpty = 1'b0;
    localparam logic [0:0]      StFull  = 1'b1;
    localparam logic [ID_W-1:0] LastId  = ID_W'(NUM_MACHINES - 1);

    // ---------------------------------------------------------------- output path
    logic [0:0]           ob_state_q, ob_state_d;
    logic [WORD_SIZE-1:0] ob_data_q, ob_data_d;
    logic [ID_W-1:0]      ob_id_q, ob_id_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;

    logic                 can_load;
    logic                 ob_load;
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [WORD_SIZE-1:0] win_data;

    assign can_load = (ob_state_q == StEmpty) || host_out_ready;
    assign ob_load  = rst_n && can_load && win_found;

    // Search starts just after the last grant so every pending requester waits at most one lap.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        win_data  = '0;
        for (int unsigned k = 1; k <= NUM_MACHINES; k++) begin
            idx = (32'(last_grant_q) + k) % NUM_MACHINES;
            if (!win_found && m_out_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
                win_data  = m_out_data[idx*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_comb begin
        m_out_ready = '0;
        for (int unsigned i = 0; i < NUM_MACHINES; i++) begin
            if (ob_load && (32'(win_id) == i)) begin
                m_out_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ob_state_d   = ob_state_q;
        ob_data_d    = ob_data_q;
        ob_id_d      = ob_id_q;
        last_grant_d = last_grant_q;
        if (ob_load) begin
            ob_state_d   = StFull;
            ob_data_d    = win_data;
            ob_id_d      = win_id;
            last_grant_d = win_id;
        end else if ((ob_state_q == StFull) && host_out_ready) begin
            ob_state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ob_state_q   <= StEmpty;
            ob_data_q    <= '0;
            ob_id_q      <= '0;
            last_grant_q <= LastId;
        end else begin
            ob_state_q   <= ob_state_d;
            ob_data_q    <= ob_data_d;
            ob_id_q      <= ob_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign host_out_valid = (ob_state_q == StFull);
    assign host_out_data  = ob_data_q;
    assign host_out_id    = ob_id_q;

    // ---------------------------------------------------------------- input path
    logic [0:0]           ib_state_q, ib_state_d;
    logic [WORD_SIZE-1:0] ib_data_q, ib_data_d;
    logic [ID_W-1:0]      ib_dest_q, ib_dest_d;
    logic                 err_q, err_d;

    logic                 in_accept;
    logic                 id_ok;
    logic                 dest_ready;

    // Ready depends only on registered state, never on downstream m_in_ready.
    assign host_in_ready = rst_n && (ib_state_q == StEmpty);
    assign in_accept     = host_in_valid && host_in_ready;
    assign id_ok         = (32'(host_in_id) < NUM_MACHINES);
    assign dest_ready    = |(m_in_valid & m_in_ready);

    always_comb begin
        m_in_valid = '0;
        for (int unsigned i = 0; i < NUM_MACHINES; i++) begin
            if ((ib_state_q == StFull) && (32'(ib_dest_q) == i)) begin
                m_in_valid[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ib_state_d = ib_state_q;
        ib_data_d  = ib_data_q;
        ib_dest_d  = ib_dest_q;
        err_d      = err_q;
        if ((ib_state_q == StFull) && dest_ready) begin
            ib_state_d = StEmpty;
        end
        if (in_accept) begin
            if (id_ok) begin
                ib_state_d = StFull;
                ib_data_d  = host_in_data;
                ib_dest_d  = host_in_id;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ib_state_q <= StEmpty;
            ib_data_q  <= '0;
            ib_dest_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            ib_state_q <= ib_state_d;
            ib_data_q  <= ib_data_d;
            ib_dest_q  <= ib_dest_d;
            err_q      <= err_d;
        end
    end

    assign m_in_data  = (ib_state_q == StFull) ? ib_data_q : '0;
    assign err_bad_id = err_q;

    // ---------------------------------------------------------------- statistics
`ifdef BF_IO_ARB_STATS_EN
    logic [NUM_MACHINES-1:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_MACHINES; i++) begin
                if (host_out_valid && host_out_ready && (32'(ob_id_q) == i) &&
                    (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign stat_out_count = cnt_q;
`else
    assign stat_out_count = '0;
`endif

endmodule
